// File: rtl/pkt_pkg.sv
// Shared constants, header layout and header packing helper for the custom IP packet packer.
package pkt_pkg;

    localparam int HEADER_BITS      = 64;
    localparam int MSG_WORD_BITS    = 32;
    localparam int BS_ID_BITS       = 8;
    localparam int FPGA_ID_BITS     = 8;
    localparam int PCKG_ID_BITS     = 16;
    localparam int TX_UID_BITS      = 8;
    localparam int RX_UID_BITS      = 8;
    localparam int VALID_BYTES_BITS = 16;

    // Field order here is the on-wire order, MSB first.
    typedef struct packed {
        logic [BS_ID_BITS-1:0]       bs_id;
        logic [FPGA_ID_BITS-1:0]     fpga_id;
        logic [PCKG_ID_BITS-1:0]     pckg_id;
        logic [TX_UID_BITS-1:0]      tx_uid;
        logic [RX_UID_BITS-1:0]      rx_uid;
        logic [VALID_BYTES_BITS-1:0] valid_bytes;
    } pkt_header_t;

    function automatic logic [HEADER_BITS-1:0] pack_header(
        input logic [BS_ID_BITS-1:0]       bs_id,
        input logic [FPGA_ID_BITS-1:0]     fpga_id,
        input logic [PCKG_ID_BITS-1:0]     pckg_id,
        input logic [TX_UID_BITS-1:0]      tx_uid,
        input logic [RX_UID_BITS-1:0]      rx_uid,
        input logic [VALID_BYTES_BITS-1:0] valid_bytes
    );
        pkt_header_t hdr;
        hdr.bs_id       = bs_id;
        hdr.fpga_id     = fpga_id;
        hdr.pckg_id     = pckg_id;
        hdr.tx_uid      = tx_uid;
        hdr.rx_uid      = rx_uid;
        hdr.valid_bytes = valid_bytes;
        return hdr;
    endfunction

endpackage

// File: rtl/pkt_skid_buffer.sv
// Two-entry register FIFO with a registered not-full flag; the head entry reads as zero when empty.
module pkt_skid_buffer #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occupancy,
    output logic             not_full
);

    logic [WIDTH-1:0] head_reg, head_next;
    logic [WIDTH-1:0] tail_reg, tail_next;
    logic [1:0]       occ_reg, occ_next;
    logic             not_full_reg, not_full_next;
    logic             push_ok, pop_ok;

    // Guard against pops when empty and pushes when full so the state can never corrupt.
    assign pop_ok  = pop && (occ_reg != 2'd0);
    assign push_ok = push && ((occ_reg != 2'd2) || pop_ok);

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        occ_next  = occ_reg;
        case (occ_reg)
            2'd0: begin
                if (push_ok) begin
                    head_next = push_data;
                    occ_next  = 2'd1;
                end
            end
            2'd1: begin
                if (push_ok && pop_ok) begin
                    head_next = push_data;
                end else if (push_ok) begin
                    tail_next = push_data;
                    occ_next  = 2'd2;
                end else if (pop_ok) begin
                    head_next = '0;
                    occ_next  = 2'd0;
                end
            end
            default: begin
                if (pop_ok) begin
                    head_next = tail_reg;
                    tail_next = push_ok ? push_data : '0;
                    occ_next  = push_ok ? 2'd2 : 2'd1;
                end
            end
        endcase
        not_full_next = (occ_next != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            occ_reg      <= 2'd0;
            not_full_reg <= 1'b0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            occ_reg      <= occ_next;
            not_full_reg <= not_full_next;
        end
    end

    assign head_data = head_reg;
    assign occupancy = occ_reg;
    assign not_full  = not_full_reg;

endmodule

// File: rtl/custom_ip_packet_packer.sv
// Packs HLS header fields and message words into one FIFO word, buffering up to two packets
// against FIFO backpressure; also counts written packets and flags writes made while full.
module custom_ip_packet_packer
    import pkt_pkg::*;
#(
    parameter int PACKET_SIZE_BITS = 256,
    parameter int NUM_MSG_WORDS    = 6,
    parameter int COUNT_WIDTH      = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [BS_ID_BITS-1:0]                  ip_bs_id,
    input  logic [FPGA_ID_BITS-1:0]                ip_fpga_id,
    input  logic [PCKG_ID_BITS-1:0]                ip_pckg_id,
    input  logic [TX_UID_BITS-1:0]                 ip_tx_uid,
    input  logic [RX_UID_BITS-1:0]                 ip_rx_uid,
    input  logic [VALID_BYTES_BITS-1:0]            ip_valid_bytes,
    input  logic [MSG_WORD_BITS*NUM_MSG_WORDS-1:0] ip_msg,
    input  logic                                   ip_write,
    output logic                                   ip_full_n,
    input  logic                                   fifo_full,
    output logic                                   wr_en,
    output logic [PACKET_SIZE_BITS-1:0]            din,
    output logic [COUNT_WIDTH-1:0]                 pkt_count,
    output logic                                   overflow_err
);

    localparam int MSG_BITS = MSG_WORD_BITS * NUM_MSG_WORDS;
    localparam int PAD_BITS = PACKET_SIZE_BITS - HEADER_BITS - MSG_BITS;

    if (PAD_BITS < 0) begin : g_size_check
        $error("PACKET_SIZE_BITS too small for header plus NUM_MSG_WORDS message words");
    end

    logic [PACKET_SIZE_BITS-1:0] packet;
    logic [1:0]                  occupancy;
    logic                        push;
    logic                        pop;
    logic                        not_full;

    assign packet[PACKET_SIZE_BITS-1 -: HEADER_BITS] =
        pack_header(ip_bs_id, ip_fpga_id, ip_pckg_id, ip_tx_uid, ip_rx_uid, ip_valid_bytes);

    // msg[0] sits directly under the header; later words follow toward the LSB.
    for (genvar gi = 0; gi < NUM_MSG_WORDS; gi++) begin : g_msg
        assign packet[PACKET_SIZE_BITS-HEADER_BITS-MSG_WORD_BITS*gi-1 -: MSG_WORD_BITS] =
            ip_msg[MSG_WORD_BITS*gi +: MSG_WORD_BITS];
    end

    if (PAD_BITS > 0) begin : g_pad
        assign packet[PAD_BITS-1:0] = '0;
    end

    assign push  = ip_write & ip_full_n;
    assign wr_en = (occupancy != 2'd0) & ~fifo_full;
    assign pop   = wr_en;

    pkt_skid_buffer #(
        .WIDTH(PACKET_SIZE_BITS)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (packet),
        .pop       (pop),
        .head_data (din),
        .occupancy (occupancy),
        .not_full  (not_full)
    );

    assign ip_full_n = not_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count    <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (pop) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (ip_write && !ip_full_n) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_custom_ip_packet_packer.sv
// Directed bench: default 256-bit packer plus a 512-bit and a 4-bit-counter variant on shared inputs.
module tb_custom_ip_packet_packer;

    logic         clk;
    logic         rst;
    logic [7:0]   ip_bs_id, ip_fpga_id, ip_tx_uid, ip_rx_uid;
    logic [15:0]  ip_pckg_id, ip_valid_bytes;
    logic [191:0] ip_msg;
    logic         ip_write;
    logic         fifo_full;

    logic         full_n_a, wr_en_a, ovf_a;
    logic [255:0] din_a;
    logic [31:0]  cnt_a;
    logic         full_n_w, wr_en_w, ovf_w;
    logic [511:0] din_w;
    logic [31:0]  cnt_w;
    logic         full_n_c, wr_en_c, ovf_c;
    logic [255:0] din_c;
    logic [3:0]   cnt_c;

    int errors = 0;
    int checks = 0;
    logic [255:0] cur_exp;

    custom_ip_packet_packer dut (
        .clk(clk), .rst(rst), .ip_bs_id(ip_bs_id), .ip_fpga_id(ip_fpga_id), .ip_pckg_id(ip_pckg_id),
        .ip_tx_uid(ip_tx_uid), .ip_rx_uid(ip_rx_uid), .ip_valid_bytes(ip_valid_bytes), .ip_msg(ip_msg),
        .ip_write(ip_write), .ip_full_n(full_n_a), .fifo_full(fifo_full), .wr_en(wr_en_a), .din(din_a),
        .pkt_count(cnt_a), .overflow_err(ovf_a)
    );

    custom_ip_packet_packer #(.PACKET_SIZE_BITS(512), .NUM_MSG_WORDS(6), .COUNT_WIDTH(32)) dut_wide (
        .clk(clk), .rst(rst), .ip_bs_id(ip_bs_id), .ip_fpga_id(ip_fpga_id), .ip_pckg_id(ip_pckg_id),
        .ip_tx_uid(ip_tx_uid), .ip_rx_uid(ip_rx_uid), .ip_valid_bytes(ip_valid_bytes), .ip_msg(ip_msg),
        .ip_write(ip_write), .ip_full_n(full_n_w), .fifo_full(fifo_full), .wr_en(wr_en_w), .din(din_w),
        .pkt_count(cnt_w), .overflow_err(ovf_w)
    );

    custom_ip_packet_packer #(.PACKET_SIZE_BITS(256), .NUM_MSG_WORDS(6), .COUNT_WIDTH(4)) dut_c4 (
        .clk(clk), .rst(rst), .ip_bs_id(ip_bs_id), .ip_fpga_id(ip_fpga_id), .ip_pckg_id(ip_pckg_id),
        .ip_tx_uid(ip_tx_uid), .ip_rx_uid(ip_rx_uid), .ip_valid_bytes(ip_valid_bytes), .ip_msg(ip_msg),
        .ip_write(ip_write), .ip_full_n(full_n_c), .fifo_full(fifo_full), .wr_en(wr_en_c), .din(din_c),
        .pkt_count(cnt_c), .overflow_err(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads a packet onto the inputs and records its expected 256-bit image in cur_exp.
    task automatic set_pkt(input logic [15:0] pckg, input logic [7:0] tag);
        ip_bs_id       = 8'hA1;
        ip_fpga_id     = 8'h02;
        ip_pckg_id     = pckg;
        ip_tx_uid      = 8'h05;
        ip_rx_uid      = 8'h06;
        ip_valid_bytes = 16'h0018;
        for (int k = 0; k < 6; k++) begin
            ip_msg[32*k +: 32] = 32'h1000_0000 + 32'(k) + {8'h00, tag, 16'h0000};
        end
        cur_exp = '0;
        cur_exp[255:192] = {8'hA1, 8'h02, pckg, 8'h05, 8'h06, 16'h0018};
        for (int k = 0; k < 6; k++) begin
            cur_exp[191-32*k -: 32] = 32'h1000_0000 + 32'(k) + {8'h00, tag, 16'h0000};
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ip_write = 1'b0;
        fifo_full = 1'b0;
        set_pkt(16'h0000, 8'h00);
        tick();
        tick();
        checks++; if (full_n_a !== 1'b0) begin errors++; $display("FAIL reset_full_n got=%b exp=0", full_n_a); end
        checks++; if (wr_en_a !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en_a); end
        checks++; if (din_a !== 256'd0) begin errors++; $display("FAIL reset_din got=%h exp=0", din_a); end
        checks++; if (cnt_a !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", ovf_a); end
        rst = 1'b0;
        tick();
        checks++; if (full_n_a !== 1'b1) begin errors++; $display("FAIL release_full_n got=%b exp=1", full_n_a); end
        $display("test_reset done: full_n=%b", full_n_a);
    endtask

    task automatic test_basic();
        set_pkt(16'h0304, 8'h00);
        ip_write = 1'b1;
        tick();
        ip_write = 1'b0;
        checks++; if (wr_en_a !== 1'b1) begin errors++; $display("FAIL basic_wr_en got=%b exp=1", wr_en_a); end
        checks++; if (din_a[255:192] !== 64'hA102_0304_0506_0018) begin errors++; $display("FAIL basic_header got=%h exp=a102030405060018", din_a[255:192]); end
        checks++; if (din_a[31:0] !== 32'h1000_0005) begin errors++; $display("FAIL basic_last_msg got=%h exp=10000005", din_a[31:0]); end
        checks++; if (din_a !== cur_exp) begin errors++; $display("FAIL basic_packet got=%h exp=%h", din_a, cur_exp); end
        checks++; if (din_w[511:448] !== 64'hA102_0304_0506_0018) begin errors++; $display("FAIL wide_header got=%h exp=a102030405060018", din_w[511:448]); end
        checks++; if (din_w[255:0] !== 256'd0) begin errors++; $display("FAIL wide_pad got=%h exp=0", din_w[255:0]); end
        checks++; if (din_w !== {cur_exp, 256'd0}) begin errors++; $display("FAIL wide_packet got=%h exp=%h", din_w, {cur_exp, 256'd0}); end
        tick();
        checks++; if (cnt_a !== 32'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", cnt_a); end
        checks++; if (wr_en_a !== 1'b0 || din_a !== 256'd0) begin errors++; $display("FAIL basic_drained wr_en=%b din=%h exp wr_en=0 din=0", wr_en_a, din_a); end
        $display("test_basic done: count=%0d", cnt_a);
    endtask

    task automatic test_back_to_back();
        logic [255:0] prev;
        prev = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                set_pkt(16'h0200 + 16'(i), 8'h20 + 8'(i));
                ip_write = 1'b1;
            end else begin
                ip_write = 1'b0;
            end
            if (i > 0) begin
                checks++; if (wr_en_a !== 1'b1 || din_a !== prev) begin errors++; $display("FAIL b2b_out%0d wr_en=%b din=%h exp wr_en=1 din=%h", i, wr_en_a, din_a, prev); end
                checks++; if (full_n_a !== 1'b1) begin errors++; $display("FAIL b2b_full_n%0d got=%b exp=1", i, full_n_a); end
            end
            prev = cur_exp;
            tick();
        end
        checks++; if (wr_en_a !== 1'b0 || cnt_a !== 32'd5) begin errors++; $display("FAIL b2b_end wr_en=%b count=%0d exp wr_en=0 count=5", wr_en_a, cnt_a); end
        $display("test_back_to_back done: count=%0d", cnt_a);
    endtask

    task automatic test_reset_mid();
        fifo_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_pkt(16'h0500 + 16'(i), 8'h50 + 8'(i));
            ip_write = 1'b1;
            tick();
        end
        ip_write = 1'b0;
        checks++; if (full_n_a !== 1'b0) begin errors++; $display("FAIL mid_full_before got=%b exp=0", full_n_a); end
        #2;
        fifo_full = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (wr_en_a !== 1'b0 || din_a !== 256'd0) begin errors++; $display("FAIL mid_reset_out wr_en=%b din=%h exp wr_en=0 din=0", wr_en_a, din_a); end
        checks++; if (cnt_a !== 32'd0 || cnt_c !== 4'd0) begin errors++; $display("FAIL mid_reset_count got=%0d/%0d exp=0/0", cnt_a, cnt_c); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (full_n_a !== 1'b1) begin errors++; $display("FAIL mid_release_full_n got=%b exp=1", full_n_a); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wr_en_a !== 1'b0 || din_a !== 256'd0) begin errors++; $display("FAIL mid_stale%0d wr_en=%b din=%h exp wr_en=0 din=0", i, wr_en_a, din_a); end
            tick();
        end
        $display("test_reset_mid done: count=%0d", cnt_a);
    endtask

    task automatic test_backpressure();
        logic [255:0] exp_q [5];
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_pkt(16'h0100 + 16'(i), 8'h10 + 8'(i));
            exp_q[i] = cur_exp;
            ip_write = 1'b1;
            tick();
            if (i == 0) begin
                checks++; if (full_n_a !== 1'b1) begin errors++; $display("FAIL bp_full_n_one got=%b exp=1", full_n_a); end
            end
            if (i == 1) begin
                checks++; if (full_n_a !== 1'b0) begin errors++; $display("FAIL bp_full_n_two got=%b exp=0", full_n_a); end
            end
        end
        ip_write = 1'b0;
        checks++; if (wr_en_a !== 1'b0 || din_a !== exp_q[0]) begin errors++; $display("FAIL bp_hold wr_en=%b din=%h exp wr_en=0 din=%h", wr_en_a, din_a, exp_q[0]); end
        fifo_full = 1'b0;
        #1;
        checks++; if (wr_en_a !== 1'b1 || din_a !== exp_q[0]) begin errors++; $display("FAIL bp_first wr_en=%b din=%h exp wr_en=1 din=%h", wr_en_a, din_a, exp_q[0]); end
        tick();
        checks++; if (wr_en_a !== 1'b1 || din_a !== exp_q[1]) begin errors++; $display("FAIL bp_second wr_en=%b din=%h exp wr_en=1 din=%h", wr_en_a, din_a, exp_q[1]); end
        checks++; if (full_n_a !== 1'b1) begin errors++; $display("FAIL bp_full_n_release got=%b exp=1", full_n_a); end
        tick();
        checks++; if (cnt_a !== 32'd2) begin errors++; $display("FAIL bp_count got=%0d exp=2", cnt_a); end
        $display("test_backpressure done: count=%0d", cnt_a);
    endtask

    task automatic test_overflow();
        // Continues from backpressure: writes were dropped while full.
        for (int i = 0; i < 3; i++) begin
            checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_sticky%0d got=%b exp=1", i, ovf_a); end
            checks++; if (wr_en_a !== 1'b0 || din_a !== 256'd0) begin errors++; $display("FAIL ovf_dropped%0d wr_en=%b din=%h exp wr_en=0 din=0", i, wr_en_a, din_a); end
            tick();
        end
        checks++; if (cnt_a !== 32'd2) begin errors++; $display("FAIL ovf_count got=%0d exp=2", cnt_a); end
        $display("test_overflow done: overflow=%b", ovf_a);
    endtask

    task automatic test_wrap();
        test_reset();
        for (int n = 1; n <= 17; n++) begin
            set_pkt(16'h0700 + 16'(n), 8'h70);
            ip_write = 1'b1;
            tick();
            ip_write = 1'b0;
            tick();
            if (n == 15) begin
                checks++; if (cnt_c !== 4'd15) begin errors++; $display("FAIL wrap_15 got=%0d exp=15", cnt_c); end
            end else if (n == 16) begin
                checks++; if (cnt_c !== 4'd0) begin errors++; $display("FAIL wrap_16 got=%0d exp=0", cnt_c); end
            end else if (n == 17) begin
                checks++; if (cnt_c !== 4'd1) begin errors++; $display("FAIL wrap_17 got=%0d exp=1", cnt_c); end
            end
        end
        checks++; if (cnt_a !== 32'd17) begin errors++; $display("FAIL wrap_wide_count got=%0d exp=17", cnt_a); end
        $display("test_wrap done: count4=%0d count32=%0d", cnt_c, cnt_a);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_backpressure();
        test_overflow();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
